// File: rtl/trigger_counter.sv
// Counts synchronised rising edges of an asynchronous trigger line while armed,
// up to a target latched at arm time, and pulses done once per completed run.
module trigger_counter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             on,
    input  logic             signal_in,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic                   rise;
    logic [WIDTH-1:0]       count_q;
    logic [WIDTH-1:0]       target_q;
    logic                   pend_q;
    logic                   done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], signal_in};
            s_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~s_prev_q;

    // Edge-completed runs raise done one cycle after count reaches the target
    // (via pend_q); a zero target completes on the first armed cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            target_q <= '0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= pend_q;
            pend_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (on) begin
                        state_q  <= S_ARMED;
                        count_q  <= '0;
                        target_q <= target;
                    end
                end
                S_ARMED: begin
                    if (!on) begin
                        state_q <= S_IDLE;
                    end else if (target_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (rise) begin
                        if (count_q == target_q - ONE) begin
                            count_q <= target_q;
                            state_q <= S_DONE;
                            pend_q  <= 1'b1;
                        end else begin
                            count_q <= count_q + ONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!on) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign count = count_q;
    assign busy  = (state_q == S_ARMED);
    assign done  = done_q;
endmodule
